// File: rtl/nb_dcache_mshr_if.sv
// LSQ and memory-bus signal bundle for the non-blocking data cache.
// The slave modport is the cache; the master modport is the LSQ/memory side.
interface nb_dcache_mshr_if #(
  parameter int unsigned NUM_LOAD_PORTS = 2
);
  logic [3:0]                   Dmem2Dcache_response;
  logic [63:0]                  Dmem2Dcache_data;
  logic [3:0]                   Dmem2Dcache_tag;
  logic [NUM_LOAD_PORTS*32-1:0] load_addr;
  logic [NUM_LOAD_PORTS-1:0]    load_en;
  logic [31:0]                  store_addr;
  logic [63:0]                  store_data;
  logic                         store_en;
  logic                         flush;
  logic [1:0]                   Dcache2Dmem_command;
  logic [31:0]                  Dcache2Dmem_addr;
  logic [63:0]                  Dcache2Dmem_data;
  logic [NUM_LOAD_PORTS*64-1:0] load_data;
  logic [NUM_LOAD_PORTS-1:0]    load_valid;
  logic                         store_accepted;
  logic                         mshr_full;

  modport master (
    output Dmem2Dcache_response, Dmem2Dcache_data, Dmem2Dcache_tag,
    output load_addr, load_en, store_addr, store_data, store_en, flush,
    input  Dcache2Dmem_command, Dcache2Dmem_addr, Dcache2Dmem_data,
    input  load_data, load_valid, store_accepted, mshr_full
  );

  modport slave (
    input  Dmem2Dcache_response, Dmem2Dcache_data, Dmem2Dcache_tag,
    input  load_addr, load_en, store_addr, store_data, store_en, flush,
    output Dcache2Dmem_command, Dcache2Dmem_addr, Dcache2Dmem_data,
    output load_data, load_valid, store_accepted, mshr_full
  );
endinterface

// File: rtl/nb_dcache_mshr.sv
// Non-blocking set-associative write-through data cache with a miss table (MSHRs),
// secondary-miss merging and per-set LRU replacement.
module nb_dcache_mshr #(
  parameter int unsigned NUM_LOAD_PORTS = 2,
  parameter int unsigned NUM_SETS       = 16,
  parameter int unsigned NUM_WAYS       = 2,
  parameter int unsigned NUM_MSHR       = 4
) (
  input logic             clock,
  input logic             reset,
  nb_dcache_mshr_if.slave bus
);
  localparam int unsigned IDX_W  = $clog2(NUM_SETS);
  localparam int unsigned TAG_W  = 29 - IDX_W;
  localparam int unsigned WAY_W  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam int unsigned AGE_W  = WAY_W;
  localparam int unsigned MSHR_W = (NUM_MSHR > 1) ? $clog2(NUM_MSHR) : 1;
  localparam logic [1:0] BUS_NONE  = 2'd0;
  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;

  typedef logic [28:0]                      blk_t;
  typedef logic [NUM_WAYS-1:0][TAG_W-1:0]   set_tag_t;
  typedef logic [NUM_WAYS-1:0][63:0]        set_data_t;
  typedef logic [NUM_WAYS-1:0][AGE_W-1:0]   set_age_t;
  typedef struct packed {
    logic             hit;
    logic [WAY_W-1:0] way;
  } way_sel_t;
  typedef enum logic [1:0] {MshrInvalid, MshrWaitIssue, MshrWaitData} mshr_state_e;

  function automatic logic [IDX_W-1:0] idx_of(input blk_t blk);
    return blk[IDX_W-1:0];
  endfunction

  function automatic logic [TAG_W-1:0] tag_of(input blk_t blk);
    return blk[28:IDX_W];
  endfunction

  function automatic way_sel_t lookup(input logic [NUM_WAYS-1:0] vld, input set_tag_t tags,
                                      input logic [TAG_W-1:0] tag);
    way_sel_t r;
    r = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (vld[w] && tags[w] == tag) begin
        r.hit = 1'b1;
        r.way = WAY_W'(w);
      end
    end
    return r;
  endfunction

  // Oldest way, optionally skipping one; hit=0 only when every way is excluded.
  function automatic way_sel_t victim(input set_age_t ages, input logic excl_en,
                                      input logic [WAY_W-1:0] excl);
    way_sel_t r;
    r = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!(excl_en && WAY_W'(w) == excl) && (!r.hit || ages[w] > ages[r.way])) begin
        r.hit = 1'b1;
        r.way = WAY_W'(w);
      end
    end
    return r;
  endfunction

  function automatic set_age_t touch(input set_age_t ages, input logic [WAY_W-1:0] way);
    set_age_t r;
    r = ages;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (ages[w] < ages[way]) r[w] = ages[w] + AGE_W'(1);
    end
    r[way] = '0;
    return r;
  endfunction

  logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
  logic [NUM_WAYS-1:0] valid_d [NUM_SETS];
  set_tag_t            tag_q   [NUM_SETS];
  set_data_t           data_q  [NUM_SETS];
  set_age_t            age_q   [NUM_SETS];
  set_age_t            age_d   [NUM_SETS];

  mshr_state_e mshr_state_q [NUM_MSHR];
  mshr_state_e mshr_state_d [NUM_MSHR];
  blk_t        mshr_blk_q   [NUM_MSHR];
  blk_t        mshr_blk_d   [NUM_MSHR];
  logic [3:0]  mshr_tag_q   [NUM_MSHR];
  logic [3:0]  mshr_tag_d   [NUM_MSHR];

  blk_t                         ld_blk [NUM_LOAD_PORTS];
  way_sel_t                     ld_sel [NUM_LOAD_PORTS];
  logic [NUM_LOAD_PORTS-1:0]    ld_hit;
  logic [NUM_LOAD_PORTS*64-1:0] ld_data;
  logic                         unused_addr_bits;

  logic              all_busy, alloc_en, merged;
  blk_t              alloc_blk, st_blk;
  logic [MSHR_W-1:0] free_idx, iss_idx, fill_idx;
  logic              iss_en, iss_ok, fill_en;
  logic              st_blocked, st_drive, st_acc;
  logic [1:0]        cmd;
  logic [31:0]       cmd_addr;
  logic [63:0]       cmd_data;

  logic              st_wr, fill_wr;
  logic [IDX_W-1:0]  st_set, fill_set;
  logic [WAY_W-1:0]  st_way, fill_way;
  way_sel_t          st_sel, fill_sel;
  blk_t              fill_blk;

  always_comb begin
    ld_hit           = '0;
    ld_data          = '0;
    unused_addr_bits = ^bus.store_addr[2:0];
    for (int p = 0; p < NUM_LOAD_PORTS; p++) begin
      ld_blk[p] = bus.load_addr[p*32+3 +: 29];
      ld_sel[p] = lookup(valid_q[idx_of(ld_blk[p])], tag_q[idx_of(ld_blk[p])],
                         tag_of(ld_blk[p]));
      ld_hit[p] = !reset && bus.load_en[p] && ld_sel[p].hit;
      ld_data[p*64 +: 64] = data_q[idx_of(ld_blk[p])][ld_sel[p].way];
      unused_addr_bits = unused_addr_bits ^ (^bus.load_addr[p*32 +: 3]);
    end
  end

  // Miss table bookkeeping, allocation and bus arbitration.
  always_comb begin
    all_busy   = 1'b1;
    free_idx   = '0;
    iss_en     = 1'b0;
    iss_idx    = '0;
    fill_en    = 1'b0;
    fill_idx   = '0;
    st_blocked = 1'b0;
    st_blk     = bus.store_addr[31:3];
    for (int m = NUM_MSHR - 1; m >= 0; m--) begin
      if (mshr_state_q[m] == MshrInvalid) begin
        all_busy = 1'b0;
        free_idx = MSHR_W'(m);
      end
      if (mshr_state_q[m] == MshrWaitIssue) begin
        iss_en  = 1'b1;
        iss_idx = MSHR_W'(m);
      end
      if (mshr_state_q[m] != MshrInvalid && mshr_blk_q[m] == st_blk) st_blocked = 1'b1;
      if (mshr_state_q[m] == MshrWaitData && |bus.Dmem2Dcache_tag &&
          mshr_tag_q[m] == bus.Dmem2Dcache_tag) begin
        fill_en  = 1'b1;
        fill_idx = MSHR_W'(m);
      end
    end
    fill_en = fill_en && !reset;

    alloc_en  = 1'b0;
    alloc_blk = '0;
    for (int p = 0; p < NUM_LOAD_PORTS; p++) begin
      merged = 1'b0;
      for (int m = 0; m < NUM_MSHR; m++) begin
        if (mshr_state_q[m] != MshrInvalid && mshr_blk_q[m] == ld_blk[p]) merged = 1'b1;
      end
      if (bus.load_en[p] && !ld_sel[p].hit && !merged && !alloc_en) begin
        alloc_en  = 1'b1;
        alloc_blk = ld_blk[p];
      end
    end
    alloc_en = alloc_en && !all_busy && !reset && !bus.flush;

    st_drive = !reset && bus.store_en && !st_blocked;
    st_acc   = st_drive && |bus.Dmem2Dcache_response;
    iss_ok   = !reset && !st_drive && iss_en && |bus.Dmem2Dcache_response;

    cmd      = BUS_NONE;
    cmd_addr = '0;
    cmd_data = '0;
    if (st_drive) begin
      cmd      = BUS_STORE;
      cmd_addr = {st_blk, 3'b000};
      cmd_data = bus.store_data;
    end else if (!reset && iss_en) begin
      cmd      = BUS_LOAD;
      cmd_addr = {mshr_blk_q[iss_idx], 3'b000};
    end

    mshr_state_d = mshr_state_q;
    mshr_blk_d   = mshr_blk_q;
    mshr_tag_d   = mshr_tag_q;
    if (iss_ok) begin
      mshr_state_d[iss_idx] = MshrWaitData;
      mshr_tag_d[iss_idx]   = bus.Dmem2Dcache_response;
    end
    if (fill_en) mshr_state_d[fill_idx] = MshrInvalid;
    if (alloc_en) begin
      mshr_state_d[free_idx] = MshrWaitIssue;
      mshr_blk_d[free_idx]   = alloc_blk;
    end
    if (bus.flush) begin
      for (int m = 0; m < NUM_MSHR; m++) mshr_state_d[m] = MshrInvalid;
    end
  end

  // Cache array updates: load-hit LRU touches, then the store, then the fill (fill ends MRU).
  always_comb begin
    valid_d = valid_q;
    age_d   = age_q;

    st_set = idx_of(st_blk);
    st_sel = lookup(valid_q[st_set], tag_q[st_set], tag_of(st_blk));
    if (!st_sel.hit) st_sel = victim(age_q[st_set], 1'b0, '0);
    st_way = st_sel.way;
    st_wr  = st_acc;

    fill_blk = mshr_blk_q[fill_idx];
    fill_set = idx_of(fill_blk);
    fill_sel = lookup(valid_q[fill_set], tag_q[fill_set], tag_of(fill_blk));
    if (!fill_sel.hit || (st_wr && st_set == fill_set && st_way == fill_sel.way)) begin
      fill_sel = victim(age_q[fill_set], st_wr && st_set == fill_set, st_way);
    end
    fill_way = fill_sel.way;
    fill_wr  = fill_en && fill_sel.hit;

    for (int p = 0; p < NUM_LOAD_PORTS; p++) begin
      if (ld_hit[p]) begin
        age_d[idx_of(ld_blk[p])] = touch(age_d[idx_of(ld_blk[p])], ld_sel[p].way);
      end
    end
    if (st_wr) begin
      valid_d[st_set][st_way] = 1'b1;
      age_d[st_set]           = touch(age_d[st_set], st_way);
    end
    if (fill_wr) begin
      valid_d[fill_set][fill_way] = 1'b1;
      age_d[fill_set]             = touch(age_d[fill_set], fill_way);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        for (int w = 0; w < NUM_WAYS; w++) age_q[s][w] <= AGE_W'(w);
      end
      for (int m = 0; m < NUM_MSHR; m++) mshr_state_q[m] <= MshrInvalid;
    end else begin
      valid_q      <= valid_d;
      age_q        <= age_d;
      mshr_state_q <= mshr_state_d;
    end
  end

  // Payload storage is qualified by valid/state bits and needs no reset.
  always_ff @(posedge clock) begin
    mshr_blk_q <= mshr_blk_d;
    mshr_tag_q <= mshr_tag_d;
    if (st_wr) begin
      tag_q[st_set][st_way]  <= tag_of(st_blk);
      data_q[st_set][st_way] <= bus.store_data;
    end
    if (fill_wr) begin
      tag_q[fill_set][fill_way]  <= tag_of(fill_blk);
      data_q[fill_set][fill_way] <= bus.Dmem2Dcache_data;
    end
  end

  assign bus.Dcache2Dmem_command = cmd;
  assign bus.Dcache2Dmem_addr    = cmd_addr;
  assign bus.Dcache2Dmem_data    = cmd_data;
  assign bus.load_valid          = ld_hit;
  assign bus.load_data           = ld_data;
  assign bus.store_accepted      = st_acc;
  assign bus.mshr_full           = all_busy && !reset;
endmodule

// File: tb/tb_nb_dcache_mshr.sv
// Directed bench for nb_dcache_mshr: 2 load ports, 16 sets, 2 ways, 4 MSHRs.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_nb_dcache_mshr;
  localparam logic [1:0] NONE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] STORE = 2'd2;

  logic clock = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  always #5 clock = ~clock;

  nb_dcache_mshr_if #(.NUM_LOAD_PORTS(2)) bus ();

  nb_dcache_mshr #(
    .NUM_LOAD_PORTS(2),
    .NUM_SETS      (16),
    .NUM_WAYS      (2),
    .NUM_MSHR      (4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ld(input logic [1:0] en, input logic [31:0] a0, input logic [31:0] a1);
    bus.load_en   = en;
    bus.load_addr = {a1, a0};
  endtask

  task automatic fill(input logic [3:0] tag, input logic [63:0] data);
    bus.Dmem2Dcache_tag  = tag;
    bus.Dmem2Dcache_data = data;
  endtask

  initial begin
    reset = 1'b1;
    bus.Dmem2Dcache_response = '0;
    bus.store_addr = '0;
    bus.store_data = '0;
    bus.store_en   = 1'b0;
    bus.flush      = 1'b0;
    fill(4'd0, 64'h0);
    ld(2'b00, 32'h0, 32'h0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rst_cmd", bus.Dcache2Dmem_command, NONE);
    chk("rst_addr", bus.Dcache2Dmem_addr, 0);
    chk("rst_data", bus.Dcache2Dmem_data, 0);
    chk("rst_lv", bus.load_valid, 0);
    chk("rst_sacc", bus.store_accepted, 0);
    chk("rst_full", bus.mshr_full, 0);

    // Cold miss to 0x100, fill with tag 3 five cycles after the accept
    @(negedge clock); ld(2'b01, 32'h100, 32'h0); #1;
    chk("cold_lv_miss", bus.load_valid, 2'b00);
    @(negedge clock); bus.Dmem2Dcache_response = 4'd3; #1;
    chk("cold_cmd", bus.Dcache2Dmem_command, LOAD);
    chk("cold_addr", bus.Dcache2Dmem_addr, 32'h100);
    @(negedge clock); bus.Dmem2Dcache_response = 4'd0; #1;
    chk("cold_no_reissue", bus.Dcache2Dmem_command, NONE);
    repeat (3) @(negedge clock);
    @(negedge clock); fill(4'd3, 64'hDEADBEEF); #1;
    chk("cold_fill_cycle_lv", bus.load_valid, 2'b00);
    @(negedge clock); fill(4'd0, 64'h0); #1;
    chk("cold_hit_lv", bus.load_valid, 2'b01);
    chk("cold_hit_data", bus.load_data[63:0], 64'hDEADBEEF);
    chk("cold_no_second", bus.Dcache2Dmem_command, NONE);

    // Two ports, same block: one BUS_LOAD only
    @(negedge clock); ld(2'b11, 32'h200, 32'h204); #1;
    chk("merge_lv_miss", bus.load_valid, 2'b00);
    @(negedge clock); bus.Dmem2Dcache_response = 4'd4; #1;
    chk("merge_cmd", bus.Dcache2Dmem_command, LOAD);
    chk("merge_addr", bus.Dcache2Dmem_addr, 32'h200);
    @(negedge clock); bus.Dmem2Dcache_response = 4'd0; #1;
    chk("merge_single_load", bus.Dcache2Dmem_command, NONE);
    chk("merge_not_full", bus.mshr_full, 0);
    @(negedge clock); fill(4'd4, 64'h1111); #1;
    @(negedge clock); fill(4'd0, 64'h0); #1;
    chk("merge_lv", bus.load_valid, 2'b11);
    chk("merge_d0", bus.load_data[63:0], 64'h1111);
    chk("merge_d1", bus.load_data[127:64], 64'h1111);

    // Fill the miss table, hit under miss, blocked allocation
    @(negedge clock); ld(2'b01, 32'h000, 32'h0); #1;
    @(negedge clock); ld(2'b01, 32'h400, 32'h0); bus.Dmem2Dcache_response = 4'd6; #1;
    chk("full_issue0", bus.Dcache2Dmem_addr, 32'h000);
    chk("full_cmd0", bus.Dcache2Dmem_command, LOAD);
    @(negedge clock); ld(2'b01, 32'h800, 32'h0); bus.Dmem2Dcache_response = 4'd7; #1;
    chk("full_issue1", bus.Dcache2Dmem_addr, 32'h400);
    @(negedge clock); ld(2'b01, 32'hC00, 32'h0); bus.Dmem2Dcache_response = 4'd8; #1;
    chk("full_issue2", bus.Dcache2Dmem_addr, 32'h800);
    chk("full_not_yet", bus.mshr_full, 0);
    @(negedge clock); ld(2'b11, 32'h1000, 32'h200); bus.Dmem2Dcache_response = 4'd9; #1;
    chk("full_issue3", bus.Dcache2Dmem_addr, 32'hC00);
    chk("full_flag", bus.mshr_full, 1);
    chk("hum_lv", bus.load_valid, 2'b10);
    chk("hum_data", bus.load_data[127:64], 64'h1111);
    @(negedge clock); bus.Dmem2Dcache_response = 4'd0; #1;
    chk("full_no_issue", bus.Dcache2Dmem_command, NONE);
    chk("full_flag_held", bus.mshr_full, 1);
    @(negedge clock); fill(4'd6, 64'hA0); #1;
    chk("full_fill_no_issue", bus.Dcache2Dmem_command, NONE);
    @(negedge clock); fill(4'd0, 64'h0); ld(2'b01, 32'h1000, 32'h0); #1;
    chk("full_freed", bus.mshr_full, 0);
    chk("full_alloc_cycle", bus.Dcache2Dmem_command, NONE);
    @(negedge clock); bus.Dmem2Dcache_response = 4'd10; #1;
    chk("full_late_cmd", bus.Dcache2Dmem_command, LOAD);
    chk("full_late_addr", bus.Dcache2Dmem_addr, 32'h1000);
    @(negedge clock); bus.Dmem2Dcache_response = 4'd0; ld(2'b00, 32'h0, 32'h0); bus.flush = 1'b1;
    @(negedge clock); bus.flush = 1'b0; #1;
    chk("flush_clears_full", bus.mshr_full, 0);

    // Store to a block with a miss in flight waits for the fill
    @(negedge clock); ld(2'b01, 32'h300, 32'h0); #1;
    chk("st_ld_miss", bus.load_valid, 2'b00);
    @(negedge clock); bus.Dmem2Dcache_response = 4'd11; #1;
    chk("st_ld_addr", bus.Dcache2Dmem_addr, 32'h300);
    @(negedge clock);
    ld(2'b00, 32'h0, 32'h0);
    bus.Dmem2Dcache_response = 4'd12;
    bus.store_en = 1'b1; bus.store_addr = 32'h300; bus.store_data = 64'h55; #1;
    chk("st_blocked_sacc", bus.store_accepted, 0);
    chk("st_blocked_cmd", bus.Dcache2Dmem_command, NONE);
    @(negedge clock); fill(4'd11, 64'h77); #1;
    chk("st_blocked_fill", bus.store_accepted, 0);
    @(negedge clock); fill(4'd0, 64'h0); #1;
    chk("st_cmd", bus.Dcache2Dmem_command, STORE);
    chk("st_addr", bus.Dcache2Dmem_addr, 32'h300);
    chk("st_data", bus.Dcache2Dmem_data, 64'h55);
    chk("st_sacc", bus.store_accepted, 1);
    @(negedge clock);
    bus.store_en = 1'b0; bus.Dmem2Dcache_response = 4'd0; ld(2'b01, 32'h300, 32'h0); #1;
    chk("st_readback_lv", bus.load_valid, 2'b01);
    chk("st_readback_d", bus.load_data[63:0], 64'h55);

    // LRU: A=0x000 resident, bring B=0x080, touch A, miss C=0x100 evicts B
    @(negedge clock); ld(2'b01, 32'h000, 32'h0); #1;
    chk("lru_a_resident", bus.load_valid, 2'b01);
    chk("lru_a_data", bus.load_data[63:0], 64'hA0);
    @(negedge clock); ld(2'b01, 32'h080, 32'h0); #1;
    chk("lru_b_miss", bus.load_valid, 2'b00);
    @(negedge clock); bus.Dmem2Dcache_response = 4'd13; #1;
    chk("lru_b_addr", bus.Dcache2Dmem_addr, 32'h080);
    @(negedge clock); bus.Dmem2Dcache_response = 4'd0; ld(2'b00, 32'h0, 32'h0);
    fill(4'd13, 64'hB0);
    @(negedge clock); fill(4'd0, 64'h0); ld(2'b01, 32'h080, 32'h0); #1;
    chk("lru_b_data", bus.load_data[63:0], 64'hB0);
    chk("lru_b_lv", bus.load_valid, 2'b01);
    @(negedge clock); ld(2'b01, 32'h000, 32'h0); #1;
    chk("lru_touch_a", bus.load_valid, 2'b01);
    @(negedge clock); ld(2'b01, 32'h100, 32'h0); #1;
    chk("lru_c_miss", bus.load_valid, 2'b00);
    @(negedge clock); bus.Dmem2Dcache_response = 4'd14; #1;
    chk("lru_c_addr", bus.Dcache2Dmem_addr, 32'h100);
    @(negedge clock); bus.Dmem2Dcache_response = 4'd0; ld(2'b00, 32'h0, 32'h0);
    fill(4'd14, 64'hC0);
    @(negedge clock); fill(4'd0, 64'h0); ld(2'b11, 32'h100, 32'h000); #1;
    chk("lru_c_a_lv", bus.load_valid, 2'b11);
    chk("lru_c_data", bus.load_data[63:0], 64'hC0);
    chk("lru_a_kept", bus.load_data[127:64], 64'hA0);
    @(negedge clock); ld(2'b01, 32'h080, 32'h0); #1;
    chk("lru_b_evicted", bus.load_valid, 2'b00);

    // Bus retry on zero response, then flush with tag 5 in flight
    @(negedge clock); ld(2'b00, 32'h0, 32'h0); #1;
    chk("retry1_cmd", bus.Dcache2Dmem_command, LOAD);
    chk("retry1_addr", bus.Dcache2Dmem_addr, 32'h080);
    @(negedge clock); #1;
    chk("retry2_cmd", bus.Dcache2Dmem_command, LOAD);
    @(negedge clock); #1;
    chk("retry3_cmd", bus.Dcache2Dmem_command, LOAD);
    @(negedge clock); bus.Dmem2Dcache_response = 4'd5; #1;
    chk("retry_accept_cmd", bus.Dcache2Dmem_command, LOAD);
    @(negedge clock); bus.Dmem2Dcache_response = 4'd0; bus.flush = 1'b1; #1;
    chk("flush_wait_data_cmd", bus.Dcache2Dmem_command, NONE);
    @(negedge clock); bus.flush = 1'b0; fill(4'd5, 64'hFF); #1;
    chk("flush_full", bus.mshr_full, 0);
    @(negedge clock); fill(4'd0, 64'h0); ld(2'b11, 32'h080, 32'h100); #1;
    chk("flush_fill_ignored", bus.load_valid, 2'b10);
    chk("flush_cache_kept", bus.load_data[127:64], 64'hC0);

    // Reset in the middle of a miss
    @(negedge clock); ld(2'b00, 32'h0, 32'h0); #1;
    chk("prereset_cmd", bus.Dcache2Dmem_command, LOAD);
    reset = 1'b1;
    @(negedge clock); reset = 1'b0; #1;
    chk("mid_rst_cmd", bus.Dcache2Dmem_command, NONE);
    chk("mid_rst_addr", bus.Dcache2Dmem_addr, 0);
    chk("mid_rst_data", bus.Dcache2Dmem_data, 0);
    chk("mid_rst_lv", bus.load_valid, 0);
    chk("mid_rst_sacc", bus.store_accepted, 0);
    chk("mid_rst_full", bus.mshr_full, 0);
    @(negedge clock); ld(2'b01, 32'h100, 32'h0); #1;
    chk("mid_rst_invalidated", bus.load_valid, 2'b00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/nb_dcache_mshr.md
Name: nb_dcache_mshr

Overview:
Parametrised, non-blocking, set-associative, write-through data cache between the LSQ (N load ports, 1 store port) and the 4-bit-tagged memory bus. Misses are tracked in an NUM_MSHR-entry miss table, so hits and further misses continue while earlier misses are outstanding. Secondary misses to an in-flight block merge onto the existing entry. LRU replacement replaces the direct-mapped single-entry-per-port scheme.

Parameters:
NUM_LOAD_PORTS, 2, number of independent load request ports.
NUM_SETS, 16, sets (power of 2); IDX_W = log2(NUM_SETS).
NUM_WAYS, 2, associativity (power of 2, 1..8); LRU age counters of log2(NUM_WAYS) bits, 0 bits when NUM_WAYS=1.
NUM_MSHR, 4, outstanding miss entries (1..15).

Ports:
clock  in  1  system clock
reset  in  1  synchronous active-high reset
Dmem2Dcache_response  in  4  nonzero = command accepted, value = transaction tag
Dmem2Dcache_data  in  64  fill data, valid with Dmem2Dcache_tag
Dmem2Dcache_tag  in  4  nonzero = fill for that tag this cycle
load_addr  in  NUM_LOAD_PORTS*32  byte address per load port
load_en  in  NUM_LOAD_PORTS  load request, held until load_valid
store_addr  in  32  store byte address (full 8-byte block write)
store_data  in  64  store data
store_en  in  1  store request, held until store_accepted
flush  in  1  discard all outstanding misses
Dcache2Dmem_command  out  2  BUS_NONE/BUS_LOAD/BUS_STORE
Dcache2Dmem_addr  out  32  block-aligned address ([2:0]=0)
Dcache2Dmem_data  out  64  store data
load_data  out  NUM_LOAD_PORTS*64  block data per port
load_valid  out  NUM_LOAD_PORTS  hit this cycle, combinational
store_accepted  out  1  store written to memory bus and cache this cycle
mshr_full  out  1  no free miss entry

Behaviour:
- Reset: reset, synchronous, active-high; clock clock. All lines invalid, LRU ages = way index, MSHRs INVALID. Outputs: command BUS_NONE, addr 0, data 0, load_valid 0, store_accepted 0, mshr_full 0.
- Address split: block = addr[31:3]; index = addr[3+:IDX_W]; tag = addr[31:3+IDX_W].
- Load hit:
  - load_valid[i] = load_en[i] && valid way with matching tag; load_data[i] = that way's data, same cycle.
  - Hit makes that way MRU at the clock edge.
  - With load_en[i]=0, load_valid[i]=0.
- Load miss:
  - If a valid MSHR holds the same block, merge; no action.
  - Otherwise allocate the lowest free MSHR into WAIT_ISSUE.
  - At most one allocation per cycle, lowest port first. Other missing ports retry next cycle, which merges when the block matches.
  - mshr_full=1 blocks allocation.
- MSHR FSM per entry:
  - INVALID -> WAIT_ISSUE on allocate.
  - WAIT_ISSUE -> WAIT_DATA when its BUS_LOAD is driven and response != 0; record mem_tag = response. On response 0, stay and retry.
  - WAIT_DATA -> INVALID when Dmem2Dcache_tag == mem_tag (nonzero). Write the fill into the set's LRU way: valid=1, make MRU. Data is visible to loads from the next cycle.
- Bus arbitration, one command per cycle:
  - Priority 1: pending store.
  - Priority 2: lowest-index WAIT_ISSUE MSHR.
  - Otherwise BUS_NONE.
  - Command, addr and data are combinational from the current state and inputs.
- Store:
  - If the block matches any valid MSHR, the store is blocked (not driven, store_accepted=0) until that entry frees.
  - Otherwise drive BUS_STORE. store_accepted = (response != 0).
  - When accepted, write the cache at the edge: hit way, or the LRU way on miss (write-allocate, full block). Make that way MRU.
- Fill and accepted store to the same set in the same cycle:
  - Store takes its way.
  - The fill goes to the LRU way among the remaining ways.
  - If NUM_WAYS=1, the fill is dropped and the MSHR still frees; the loads re-miss.
- A fill and a hit in the same set in the same cycle apply both LRU updates; the fill is applied last (fill way becomes MRU).
- LRU: accessed way age -> 0; ways younger than its old age increment; the victim is the oldest way (age NUM_WAYS-1).
- flush: at the edge all MSHRs -> INVALID. Later fills with their tags are ignored. Cache contents and LRU are retained. A store accepted in the flush cycle still commits.
- mshr_full = all MSHRs non-INVALID (registered state).

Test Plan:
- Cold miss then hit:
  - Stimulus: load_en[0], addr 0x100. Cycle 0: BUS_LOAD 0x100; response 3.
  - Fill: tag 3 with data 0xDEAD_BEEF arrives 5 cycles later.
  - Required: load_valid[0]=1, data 0xDEADBEEF on the following cycle; no second BUS_LOAD.
- Merge:
  - Stimulus: port0 0x200, port1 0x204 (same block) in the same cycle.
  - Required: exactly one BUS_LOAD 0x200; one MSHR used; both ports valid on fill.
- Hit under miss and MSHR full (NUM_MSHR=4):
  - Stimulus: misses to 0x000, 0x400, 0x800, 0xC00 accepted, then a hit to a resident block, then a miss to 0x1000.
  - Required: the hit is valid immediately; mshr_full=1 and 0x1000 is not issued until a fill frees an entry.
- Store blocked by pending miss:
  - Stimulus: load miss 0x300 in WAIT_DATA; store 0x300 data 0x55.
  - Required: store_accepted=0 until the fill; then BUS_STORE; a later load 0x300 returns 0x55.
- LRU, 2-way, NUM_SETS=16:
  - Stimulus: fill A=0x000 and B=0x080, access A, then miss C=0x100.
  - Required: C replaces B; A still hits.
- Retry, flush and reset:
  - Stimulus: response 0 for 3 cycles.
  - Required: BUS_LOAD re-driven each cycle.
  - Stimulus: flush while in WAIT_DATA tag 5; then tag 5 fill arrives.
  - Required: cache unchanged, mshr_full=0.
  - Stimulus: reset asserted mid-miss.
  - Required: all outputs return to reset values next cycle.
